viterbi_decoder: RTL and testbench

VITERBI_DECODER -- requirements
Module: viterbi_decoder

---
 rtl/viterbi_pkg.sv | 39 +++
 rtl/viterbi_acs.sv | 28 ++
 rtl/viterbi_decoder.sv | 156 +++++++++++++++
 tb/tb_viterbi_decoder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants, controller state type and trellis helpers for the
// hard-decision rate-1/2 Viterbi decoder (K=3 and K=4 codes).
package viterbi_pkg;

  localparam int NUM_STATES   = 8;
  localparam int DEF_TB_DEPTH = 16;
  localparam int DEF_PM_W     = 6;
  localparam int INIT_METRIC  = 8;

  // Generator MSB taps the current input bit; lower bits tap older inputs.
  localparam logic [2:0] G0_K3 = 3'b111;
  localparam logic [2:0] G1_K3 = 3'b101;
  localparam logic [3:0] G0_K4 = 4'b1111;
  localparam logic [3:0] G1_K4 = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } ctl_state_t;

  // Encoder output for input bit u leaving state pred (most recent bit is MSB).
  function automatic logic [1:0] branch_sym(input logic k4, input logic [2:0] pred,
                                            input logic u);
    logic [3:0] r4;
    logic [2:0] r3;
    r4 = {u, pred};
    r3 = {u, pred[1:0]};
    if (k4) branch_sym = {^(r4 & G0_K4), ^(r4 & G1_K4)};
    else    branch_sym = {^(r3 & G0_K3), ^(r3 & G1_K3)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    hamming2 = {x[1] & x[0], x[1] ^ x[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state; modular metrics compared by
// the sign of their difference, predecessor 0 wins ties.
module viterbi_acs
  import viterbi_pkg::*;
#(
  parameter int PM_W = DEF_PM_W
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [1:0]      bm0,
  input  logic [1:0]      bm1,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);

  logic [PM_W-1:0] cand0;
  logic [PM_W-1:0] cand1;
  logic [PM_W-1:0] diff;

  always_comb begin
    cand0  = pm0 + {{(PM_W-2){1'b0}}, bm0};
    cand1  = pm1 + {{(PM_W-2){1'b0}}, bm1};
    diff   = cand1 - cand0;
    dec    = diff[PM_W-1];
    pm_new = dec ? cand1 : cand0;
  end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder, K=3/K=4 selectable, register-exchange
// survivors of depth TB_DEPTH, one decoded bit per accepted symbol.
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = DEF_TB_DEPTH,
  parameter int PM_W     = DEF_PM_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  input  logic [1:0]      encoded_sym,
  input  logic            choose_constraint_length,
  output logic            out_valid,
  output logic            decoded_bit,
  output logic [PM_W-1:0] best_metric,
  output ctl_state_t      dbg_state
);

  // Valid-only stream: a symbol is accepted on a rising edge with in_valid=1
  // and start=0; out_valid is a one-cycle pulse; no backpressure either way.

  localparam int              CNT_W     = $clog2(TB_DEPTH + 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(TB_DEPTH - 1);
  localparam logic [PM_W-1:0]  INIT_PM   = PM_W'(INIT_METRIC);

  ctl_state_t          state_q, state_d;
  logic [CNT_W-1:0]    fill_q, fill_d;
  logic                k4_q;
  logic                mode_k4;
  logic                accept;
  logic                emit;
  logic [PM_W-1:0]     pm_q   [NUM_STATES];
  logic [PM_W-1:0]     pm_n   [NUM_STATES];
  logic [TB_DEPTH-1:0] hist_q [NUM_STATES];
  logic [TB_DEPTH-1:0] hist_n [NUM_STATES];
  logic [2:0]          best_idx;

  function automatic logic pm_less(input logic [PM_W-1:0] a, input logic [PM_W-1:0] b);
    logic [PM_W-1:0] d;
    d = a - b;
    return d[PM_W-1];
  endfunction

  assign accept    = in_valid & ~start;
  // The first symbol is decoded with the live mode input; later ones use the latch.
  assign mode_k4   = (state_q == ST_IDLE) ? choose_constraint_length : k4_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    emit    = 1'b0;
    if (start) begin
      state_d = ST_IDLE;
      fill_d  = '0;
    end else if (in_valid) begin
      case (state_q)
        ST_IDLE, ST_FILL: begin
          fill_d = fill_q + CNT_W'(1);
          if (fill_q == FILL_LAST) begin
            state_d = ST_RUN;
            emit    = 1'b1;
          end else begin
            state_d = ST_FILL;
          end
        end
        default: emit = 1'b1;
      endcase
    end
  end

  for (genvar s = 0; s < NUM_STATES; s++) begin : g_state
    localparam logic [2:0] SI    = 3'(s);
    localparam bit         UPPER = (s >= 4);

    logic [2:0]      p0_idx, p1_idx;
    logic            u_bit;
    logic [1:0]      bm0, bm1;
    logic [PM_W-1:0] acs_pm;
    logic            acs_dec;

    // Predecessors differ only in the dropped (oldest) state bit.
    always_comb begin
      if (mode_k4) begin
        p0_idx = {SI[1:0], 1'b0};
        p1_idx = {SI[1:0], 1'b1};
        u_bit  = SI[2];
      end else begin
        p0_idx = {1'b0, SI[0], 1'b0};
        p1_idx = {1'b0, SI[0], 1'b1};
        u_bit  = SI[1];
      end
      bm0 = hamming2(encoded_sym, branch_sym(mode_k4, p0_idx, u_bit));
      bm1 = hamming2(encoded_sym, branch_sym(mode_k4, p1_idx, u_bit));
    end

    viterbi_acs #(.PM_W(PM_W)) u_acs (
      .pm0    (pm_q[p0_idx]),
      .pm1    (pm_q[p1_idx]),
      .bm0    (bm0),
      .bm1    (bm1),
      .pm_new (acs_pm),
      .dec    (acs_dec)
    );

    assign pm_n[s]   = (UPPER && !mode_k4) ? {PM_W{1'b1}} : acs_pm;
    assign hist_n[s] = acs_dec ? {hist_q[p1_idx][TB_DEPTH-2:0], u_bit}
                               : {hist_q[p0_idx][TB_DEPTH-2:0], u_bit};
  end

  // Lowest index wins ties; states 4-7 are excluded in K=3 mode.
  always_comb begin
    best_idx = '0;
    for (int i = 1; i < NUM_STATES; i++) begin
      if ((mode_k4 || i < 4) && pm_less(pm_n[i], pm_n[best_idx])) best_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fill_q      <= '0;
      k4_q        <= 1'b0;
      out_valid   <= 1'b0;
      decoded_bit <= 1'b0;
      best_metric <= '0;
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : INIT_PM;
        hist_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      out_valid <= emit;
      if (state_q == ST_IDLE && accept) k4_q <= choose_constraint_length;
      if (start) begin
        decoded_bit <= 1'b0;
        best_metric <= '0;
        for (int i = 0; i < NUM_STATES; i++) begin
          pm_q[i]   <= (i == 0) ? '0 : INIT_PM;
          hist_q[i] <= '0;
        end
      end else if (in_valid) begin
        best_metric <= pm_n[best_idx];
        if (emit) decoded_bit <= hist_n[best_idx][TB_DEPTH-1];
        for (int i = 0; i < NUM_STATES; i++) begin
          pm_q[i]   <= pm_n[i];
          hist_q[i] <= hist_n[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench for viterbi_decoder: directed vector table, start/reset
// corner cases and random streams against a behavioural encoder/scoreboard.
module tb_viterbi_decoder;
  import viterbi_pkg::*;

  localparam int D    = 16;
  localparam int PM_W = 6;
  localparam int NVEC = 24;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic [1:0]      encoded_sym = 2'b00;
  logic            cfg_k4 = 1'b0;
  logic            out_valid;
  logic            decoded_bit;
  logic [PM_W-1:0] best_metric;
  ctl_state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  // scoreboard state
  logic [0:0] exp_q[$];
  bit         mon_en = 1'b0;
  logic       acc_seen;
  int         n_acc = 0;
  int         n_out = 0;
  int         acc_base = 0;
  int         out_base = 0;

  typedef struct {
    logic [1:0]      sym;
    logic            exp_valid;
    logic            exp_bit;
    logic [PM_W-1:0] exp_metric;
  } vec_t;

  vec_t       tbl[NVEC];
  logic [1:0] tsyms[9];
  logic       tdata[8];

  always #5 clk = ~clk;

  viterbi_decoder #(.TB_DEPTH(D), .PM_W(PM_W)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .start                    (start),
    .in_valid                 (in_valid),
    .encoded_sym              (encoded_sym),
    .choose_constraint_length (cfg_k4),
    .out_valid                (out_valid),
    .decoded_bit              (decoded_bit),
    .best_metric              (best_metric),
    .dbg_state                (dbg_state)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_seen <= 1'b0;
    else        acc_seen <= in_valid && !start;
  end

  always @(posedge clk) begin
    if (rst_n && in_valid && !start) n_acc <= n_acc + 1;
  end

  // Monitor: every pulse must follow an accepted symbol, sit exactly D-1
  // symbols behind its input, and carry the next expected bit.
  always @(negedge clk) begin
    if (mon_en && rst_n && out_valid) begin
      checks++;
      if (!acc_seen || (n_acc - acc_base) != D + (n_out - out_base)) begin
        errors++;
        $display("FAIL out_timing accepted=%0d outputs=%0d after_accept=%0d required_accepted=%0d",
                 n_acc - acc_base, n_out - out_base, acc_seen, D + (n_out - out_base));
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_output got=%0d required=none", decoded_bit);
      end else begin
        logic [0:0] e;
        e = exp_q.pop_front();
        if (decoded_bit !== e) begin
          errors++;
          $display("FAIL decoded_bit output#%0d got=%0d required=%0d",
                   n_out - out_base, decoded_bit, e);
        end
      end
      n_out++;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] sym);
    @(negedge clk);
    in_valid    = v;
    encoded_sym = sym;
  endtask

  task automatic do_start(input logic k4);
    @(negedge clk);
    start       = 1'b1;
    in_valid    = 1'($urandom_range(0, 1));
    encoded_sym = 2'($urandom);
    cfg_k4      = k4;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    check("start_state", int'(dbg_state), int'(ST_IDLE));
    check("start_out_valid", int'(out_valid), 0);
    check("start_metric", int'(best_metric), 0);
  endtask

  // Convolutional encoder from its definition: parity j-th tap on the input
  // j symbols back, encoder starting from all-zero history.
  task automatic encode(input logic k4, input logic data[$], output logic [1:0] syms[$]);
    int g0[4];
    int g1[4];
    int klen;
    if (k4) begin
      g0 = '{1, 1, 1, 1};
      g1 = '{1, 1, 0, 1};
      klen = 4;
    end else begin
      g0 = '{1, 1, 1, 0};
      g1 = '{1, 0, 1, 0};
      klen = 3;
    end
    syms.delete();
    for (int n = 0; n < data.size(); n++) begin
      int p0;
      int p1;
      p0 = 0;
      p1 = 0;
      for (int j = 0; j < klen; j++) begin
        if (n >= j) begin
          p0 ^= g0[j] & int'(data[n-j]);
          p1 ^= g1[j] & int'(data[n-j]);
        end
      end
      syms.push_back({1'(p0), 1'(p1)});
    end
  endtask

  // err_mode: 0 none, 1 single flip at symbol 5, 2 flips spaced 16..24 apart.
  task automatic run_stream(input string tag, input logic k4, input int nbits,
                            input int err_mode, input int gap_pct,
                            input bit toggle_cfg, input bit do_st);
    logic       data[$];
    logic [1:0] syms[$];
    int         total;
    int         n_err;
    int         pos;
    if (do_st) do_start(k4);
    else cfg_k4 = k4;
    for (int i = 0; i < nbits; i++) data.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < D; i++) data.push_back(1'b0);
    total = data.size();
    encode(k4, data, syms);
    n_err = 0;
    if (err_mode == 1) begin
      syms[5] = syms[5] ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
      n_err = 1;
    end else if (err_mode == 2) begin
      pos = $urandom_range(4, 10);
      while (pos < total - 24) begin
        syms[pos] = syms[pos] ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
        n_err++;
        pos += $urandom_range(16, 24);
      end
    end
    exp_q.delete();
    for (int i = 0; i < total; i++) exp_q.push_back(data[i]);
    acc_base = n_acc;
    out_base = n_out;
    mon_en   = 1'b1;
    for (int i = 0; i < total; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) drive(1'b0, 2'($urandom));
      if (toggle_cfg && i == total / 2) cfg_k4 = ~cfg_k4;
      drive(1'b1, syms[i]);
    end
    drive(1'b0, 2'($urandom));
    repeat (2) @(negedge clk);
    check({tag, "_outputs"}, n_out - out_base, total - D + 1);
    check({tag, "_metric"}, int'(best_metric), n_err);
    check({tag, "_state"}, int'(dbg_state), int'(ST_RUN));
    mon_en = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_decoded_bit", int'(decoded_bit), 0);
    check("rst_best_metric", int'(best_metric), 0);
    check("rst_state", int'(dbg_state), int'(ST_IDLE));
    rst_n = 1'b1;

    // directed K=3 noiseless vector: 1,0,1,1,0,0,1,0 then zeros
    tsyms = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b11};
    tdata = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < NVEC; i++) begin
      tbl[i].sym        = (i < 9) ? tsyms[i] : 2'b00;
      tbl[i].exp_valid  = (i >= D - 1);
      tbl[i].exp_bit    = (i >= D - 1 && i - (D - 1) < 8) ? tdata[i-(D-1)] : 1'b0;
      tbl[i].exp_metric = '0;
    end
    do_start(1'b0);
    for (int i = 0; i <= NVEC; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("tbl_valid[%0d]", i - 1), int'(out_valid), int'(tbl[i-1].exp_valid));
        if (tbl[i-1].exp_valid)
          check($sformatf("tbl_bit[%0d]", i - 1), int'(decoded_bit), int'(tbl[i-1].exp_bit));
        check($sformatf("tbl_metric[%0d]", i - 1), int'(best_metric), int'(tbl[i-1].exp_metric));
      end
      if (i < NVEC) begin
        in_valid    = 1'b1;
        encoded_sym = tbl[i].sym;
      end else begin
        in_valid = 1'b0;
      end
    end
    check("tbl_state", int'(dbg_state), int'(ST_RUN));

    // start and in_valid together: start wins, symbol discarded
    @(negedge clk);
    start       = 1'b1;
    in_valid    = 1'b1;
    encoded_sym = 2'b11;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    check("start_wins_state", int'(dbg_state), int'(ST_IDLE));
    check("start_wins_valid", int'(out_valid), 0);
    @(negedge clk);
    check("start_wins_discard", int'(dbg_state), int'(ST_IDLE));

    // random streams against the encoder model
    run_stream("k3_err5", 1'b0, 64, 1, 0, 1'b0, 1'b1);
    run_stream("k4_errs", 1'b1, 200, 2, 0, 1'b0, 1'b1);
    run_stream("k3_gaps", 1'b0, 80, 0, 50, 1'b0, 1'b1);
    run_stream("k4_gaps", 1'b1, 80, 0, 50, 1'b0, 1'b1);
    run_stream("k3_toggle", 1'b0, 60, 0, 0, 1'b1, 1'b1);
    run_stream("k4_after_start", 1'b1, 60, 0, 0, 1'b0, 1'b1);
    run_stream("k4_toggle", 1'b1, 60, 0, 20, 1'b1, 1'b1);
    run_stream("k3_after_start", 1'b0, 60, 0, 0, 1'b0, 1'b1);

    // asynchronous reset at symbol 30 of a K=3 stream
    begin
      logic       data[$];
      logic [1:0] syms[$];
      do_start(1'b0);
      for (int i = 0; i < 40; i++) data.push_back(1'($urandom_range(0, 1)));
      encode(1'b0, data, syms);
      exp_q.delete();
      for (int i = 0; i < 40; i++) exp_q.push_back(data[i]);
      acc_base = n_acc;
      out_base = n_out;
      mon_en   = 1'b1;
      for (int i = 0; i < 30; i++) drive(1'b1, syms[i]);
      @(posedge clk);
      #2;
      check("pre_reset_valid", int'(out_valid), 1);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("async_rst_valid", int'(out_valid), 0);
      check("async_rst_bit", int'(decoded_bit), 0);
      check("async_rst_metric", int'(best_metric), 0);
      check("async_rst_state", int'(dbg_state), int'(ST_IDLE));
      mon_en = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_valid", int'(out_valid), 0);
      run_stream("k3_after_reset", 1'b0, 24, 0, 0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
